// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M/RV64M multiply/divide unit with valid/ready
// handshake, tag pass-through and pipeline flush.
//   Multiply: shift-add, MUL_BITS multiplier bits per cycle on a 2*XLEN acc.
//   Divide:   restoring, one quotient bit per cycle.
//   Divide-by-zero and signed overflow complete on a 1-cycle fast path.
// Optional feature macro: MULDIV_DIVREM_FUSE_EN -- a one-entry cache of the
// last normal-path division so a matching DIV/REM pair finishes in 1 cycle.
module muldiv_iter #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 2,
   parameter int TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   localparam logic [6:0]      MUL_LAST = 7'(XLEN / MUL_BITS - 1);
   localparam logic [6:0]      DIV_LAST = 7'(XLEN - 1);
   localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic [XLEN-1:0]     a_mag_q, a_mag_d, b_mag_q, b_mag_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [6:0]          cnt_q, cnt_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [XLEN-1:0]     result_q, result_d;

   // request decode
   logic                accept, req_sa, req_sb, req_a_neg, req_b_neg;
   logic [XLEN-1:0]     req_a_mag, req_b_mag;
   logic                b_zero, ovf, req_fast, fuse_hit;
   logic [XLEN-1:0]     fast_res, fuse_res;

   // datapath
   logic [MUL_BITS-1:0]        mul_digit;
   logic [XLEN+MUL_BITS-1:0]   mul_sum;
   logic [2*XLEN+MUL_BITS-1:0] mul_cat;
   logic [2*XLEN-1:0]          mul_next, div_next, prod;
   logic [XLEN:0]              div_tmp, div_diff;
   logic [XLEN-1:0]            q_fix, r_fix, fix_res;
   logic [6:0]                 cnt_last;

   assign req_ready   = (state_q == IDLE) && !flush;
   assign accept      = req_valid && req_ready;
   assign resp_valid  = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign resp_result = result_q;
   assign resp_tag    = tag_q;

   // operand sign/magnitude split and fast-path result selection
   always_comb begin
      req_sa    = (req_op == 3'd0) || (req_op == 3'd1) || (req_op == 3'd2) ||
                  (req_op == 3'd4) || (req_op == 3'd6);
      req_sb    = (req_op == 3'd0) || (req_op == 3'd1) ||
                  (req_op == 3'd4) || (req_op == 3'd6);
      req_a_neg = req_sa && req_a[XLEN-1];
      req_b_neg = req_sb && req_b[XLEN-1];
      req_a_mag = req_a_neg ? -req_a : req_a;
      req_b_mag = req_b_neg ? -req_b : req_b;
      b_zero    = (req_b == '0);
      // op[0] set means unsigned division, op[1] set means remainder
      ovf       = !req_op[0] && (req_a == XMIN) && (req_b == '1);
      req_fast  = req_op[2] && (b_zero || ovf || fuse_hit);
      if (b_zero)   fast_res = req_op[1] ? req_a : '1;
      else if (ovf) fast_res = req_op[1] ? '0 : XMIN;
      else          fast_res = fuse_res;
   end

   // one iteration of shift-add multiply and restoring divide, plus fix-up
   always_comb begin
      mul_digit = acc_q[MUL_BITS-1:0];
      mul_sum   = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
                  ({{MUL_BITS{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, mul_digit});
      mul_cat   = {mul_sum, acc_q[XLEN-1:0]};
      mul_next  = mul_cat[2*XLEN+MUL_BITS-1:MUL_BITS];

      // acc holds {remainder, dividend/quotient}
      div_tmp   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_tmp - {1'b0, b_mag_q};
      if (!div_diff[XLEN]) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 div_next = {div_tmp[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};

      prod      = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
      q_fix     = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      r_fix     = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (op_q[2])           fix_res = op_q[1] ? r_fix : q_fix;
      else if (op_q == 3'd0) fix_res = prod[XLEN-1:0];
      else                   fix_res = prod[2*XLEN-1:XLEN];
      cnt_last  = op_q[2] ? DIV_LAST : MUL_LAST;
   end

   // control FSM next-state and datapath register updates
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      result_d = result_q;
      case (state_q)
         IDLE: if (accept) begin
            op_d    = req_op;
            a_neg_d = req_a_neg;
            b_neg_d = req_b_neg;
            a_mag_d = req_a_mag;
            b_mag_d = req_b_mag;
            tag_d   = req_tag;
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, (req_op[2] ? req_a_mag : req_b_mag)};
            if (req_fast) begin
               result_d = fast_res;
               state_d  = DONE;
            end else begin
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_d = op_q[2] ? div_next : mul_next;
            if (cnt_q == cnt_last) begin
               cnt_d   = '0;
               state_d = FIXUP;
            end else begin
               cnt_d   = cnt_q + 7'd1;
            end
         end
         FIXUP: begin
            result_d = fix_res;
            state_d  = DONE;
         end
         DONE: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // flush wins over everything, including a same-cycle handshake
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   // main state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         tag_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         tag_q    <= tag_d;
         result_q <= result_d;
      end
   end

`ifdef MULDIV_DIVREM_FUSE_EN
   logic            fuse_vld_q, fuse_vld_d, fuse_sgn_q, fuse_sgn_d;
   logic [XLEN-1:0] fuse_a_q, fuse_a_d, fuse_b_q, fuse_b_d;
   logic [XLEN-1:0] fuse_quo_q, fuse_quo_d, fuse_rem_q, fuse_rem_d;
   logic [XLEN-1:0] raw_a_q, raw_a_d, raw_b_q, raw_b_d;

   // cache lookup against the incoming request
   always_comb begin
      fuse_hit = fuse_vld_q && req_op[2] && (fuse_sgn_q == !req_op[0]) &&
                 (fuse_a_q == req_a) && (fuse_b_q == req_b);
      fuse_res = req_op[1] ? fuse_rem_q : fuse_quo_q;
   end

   // keep raw operands of the running op; fill cache when a division finishes
   always_comb begin
      raw_a_d    = raw_a_q;
      raw_b_d    = raw_b_q;
      fuse_vld_d = fuse_vld_q;
      fuse_sgn_d = fuse_sgn_q;
      fuse_a_d   = fuse_a_q;
      fuse_b_d   = fuse_b_q;
      fuse_quo_d = fuse_quo_q;
      fuse_rem_d = fuse_rem_q;
      if (accept) begin
         raw_a_d = req_a;
         raw_b_d = req_b;
      end
      if ((state_q == FIXUP) && op_q[2] && !flush) begin
         fuse_vld_d = 1'b1;
         fuse_sgn_d = !op_q[0];
         fuse_a_d   = raw_a_q;
         fuse_b_d   = raw_b_q;
         fuse_quo_d = q_fix;
         fuse_rem_d = r_fix;
      end
   end

   // cache registers; only reset invalidates
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         raw_a_q    <= '0;
         raw_b_q    <= '0;
         fuse_vld_q <= 1'b0;
         fuse_sgn_q <= 1'b0;
         fuse_a_q   <= '0;
         fuse_b_q   <= '0;
         fuse_quo_q <= '0;
         fuse_rem_q <= '0;
      end else begin
         raw_a_q    <= raw_a_d;
         raw_b_q    <= raw_b_d;
         fuse_vld_q <= fuse_vld_d;
         fuse_sgn_q <= fuse_sgn_d;
         fuse_a_q   <= fuse_a_d;
         fuse_b_q   <= fuse_b_d;
         fuse_quo_q <= fuse_quo_d;
         fuse_rem_q <= fuse_rem_d;
      end
   end
`else
   assign fuse_hit = 1'b0;
   assign fuse_res = '0;
`endif

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised, handshaked iterative multiply/divide unit for the RV32M/RV64M execute stage. It generalises the fixed 32-bit mul/div wrapper in three ways: XLEN and multiplier radix are parameters, requests and responses use valid/ready with a tag and a pipeline flush, and the RISC-V divide corner cases complete on a 1-cycle fast path. It sits beside the ALU in EX and stalls the pipe through `req_ready` and `resp_valid`.

## Interface
- `XLEN`, 32 — operand and result width; 32 or 64.
- `MUL_BITS`, 2 — multiplier bits retired per cycle; one of 1, 2, 4, 8; must divide XLEN.
- `TAG_W`, 5 — width of the opaque request tag (destination register index).

- `clk` in 1 — clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `flush` in 1 — abandon any in-flight operation; no response is produced.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — high only in IDLE with `flush` low.
- `req_op` in 3 — 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `req_a`, `req_b` in XLEN — rs1 and rs2.
- `req_tag` in TAG_W — returned unchanged with the result.
- `resp_valid` out 1 — result present; held until accepted.
- `resp_ready` in 1 — consumer accepts the result.
- `resp_result` out XLEN — result value.
- `resp_tag` out TAG_W — tag of the result.
- `busy` out 1 — state is not IDLE.

## Operation
- **Accept:** the request is accepted when `req_valid && req_ready` at a rising edge. Op, operand magnitudes, sign flags and tag are latched.
- **Signedness:**
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - Other ops: both unsigned.
  - Datapath works on magnitudes.
- **Sign of result:**
  - Product negated if sign(a)^sign(b).
  - Quotient negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
- **Multiply:** shift-add on a 2·XLEN accumulator, MUL_BITS multiplier bits per CALC cycle.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits after sign fix-up of the full 2·XLEN product.
- **Divide:** restoring, 1 quotient bit per CALC cycle.
- **Fast path** (no CALC, no FIXUP; goes straight to DONE):
  - b==0: quotient = all-ones, remainder = a (unsigned and signed).
  - Signed overflow, a==MIN and b==−1 (DIV/REM only): quotient = MIN, remainder = 0.
- **FSM:**
  - IDLE → CALC on a normal accept; IDLE → DONE on a fast-path accept.
  - CALC → FIXUP when the iteration counter reaches N−1.
  - FIXUP → DONE: sign correction and high/low select, registered into `resp_result`.
  - DONE → IDLE on `resp_ready`.
- **Flush:** `flush` in any state moves to IDLE at the next edge and drops `resp_valid`. A result in DONE is discarded even if `resp_ready` is high in the same cycle. With `flush` high, `req_ready` is 0, so no request is accepted.
- **Reset:** asserting `rst` at any time, including mid-CALC, forces IDLE immediately.
  - `resp_valid`=0, `resp_result`=0, `resp_tag`=0, `busy`=0, counter=0.
  - `req_ready` reads 1 once in IDLE.
  - The fuse cache is invalidated.

## Timing
- Accept edge = cycle 0. Let N = XLEN/MUL_BITS for multiply, N = XLEN for divide.
- **Normal op:** CALC occupies cycles 1..N, FIXUP is cycle N+1, and `resp_valid` rises in cycle N+2.
  - XLEN=32, MUL_BITS=2: multiply 18 cycles, divide 34 cycles.
- **Fast path:** `resp_valid` in cycle 1.
- **Back-pressure:** `resp_result` and `resp_tag` are stable while `resp_valid && !resp_ready`.
- **Throughput:** the next request can be accepted no earlier than the cycle after the response handshake. `req_ready` is combinational from state and `flush`.

## Configuration
- Macro: `MULDIV_DIVREM_FUSE_EN`.
- **Defined:**
  - On every normal-path DIV/DIVU/REM/REMU completion, a cache stores a, b, signedness, signed quotient, signed remainder and a valid bit.
  - A later DIV/REM (signed) or DIVU/REMU (unsigned) with identical a, b and signedness takes the fast path: `resp_valid` in cycle 1 with the cached quotient or remainder.
  - Flush does not invalidate the cache; reset does.
- **Undefined:** no cache is present and every non-corner division takes XLEN+2 cycles.

## Test plan
- MUL a=−7 (0xFFFFFFF9), b=3, tag 5 → `resp_valid` in cycle 18, result 0xFFFFFFEB, tag 5. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=−1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → result 0xFFFFFFFA in cycle 34. REM −20/3 → 0xFFFFFFFE. DIVU 20/3 → 6. REMU 20/3 → 2.
- DIVU 5/0 → 0xFFFFFFFF in cycle 1. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000 in cycle 1. REM of the same operands → 0.
- MUL with `resp_ready` low for 10 cycles after `resp_valid` → result and tag stable, `req_ready`=0 throughout. Handshake, then `req_ready`=1 the next cycle.
- DIV started, `flush` pulsed in cycle 10 → IDLE in cycle 11, no `resp_valid`. Separately, `rst` asserted mid-CALC → all outputs at reset values immediately.
- With `MULDIV_DIVREM_FUSE_EN`: DIV 100/7 (cycle 34, 14) then REM 100/7 → 2 in cycle 1. Without the macro, the REM takes 34 cycles.
